// File: rtl/lenet_seq_pkg.sv
// Shared constants for the LeNet layer sequencer: FSM state codes, stage indices, default widths.
package lenet_seq_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam int unsigned STG_CONV1 = 0;
    localparam int unsigned STG_POOL1 = 1;
    localparam int unsigned STG_CONV2 = 2;
    localparam int unsigned STG_POOL2 = 3;
    localparam int unsigned STG_FC1   = 4;
    localparam int unsigned STG_FC2   = 5;

    localparam int unsigned DEFAULT_ANS_W = 4;

endpackage

// File: rtl/lenet_layer_sequencer_watchdog.sv
// Per-stage watchdog: counts consecutive RUN cycles and flags expiry at TIMEOUT_CYC.
module seq_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    // RUN is always entered from IDLE or GAP, so clearing outside RUN clears on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = run && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lenet_layer_sequencer.sv
// LeNet frame controller: hands a one-hot enable through the layer engines in order.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module lenet_layer_sequencer
    import lenet_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 6,
    parameter int unsigned ANS_W       = DEFAULT_ANS_W,
    parameter int unsigned FRAME_CNT_W = 16,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [NUM_STAGES-1:0]         stage_en,
    input  logic [NUM_STAGES-1:0]         stage_finish,
    input  logic [ANS_W-1:0]              fc_ans,
    output logic                          busy,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic                          done,
    output logic [ANS_W-1:0]              ans,
    output logic                          ans_valid,
    output logic [FRAME_CNT_W-1:0]        frame_cnt,
    output logic                          err
);

    localparam int unsigned IDX_W = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("lenet_layer_sequencer: NUM_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic             finish_hit;
    logic             timeout;

    assign finish_hit = stage_finish[idx];

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    idx_nx   = IDX_W'(STG_CONV1);
                end
            end
            RUN: begin
                if (finish_hit) begin
                    if (idx == LAST_IDX) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = GAP;
                        idx_nx   = idx + IDX_W'(1);
                    end
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            GAP:     state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Enable is decoded from the next state so it is a clean register output with latency 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            stage_en  <= '0;
            ans       <= '0;
            ans_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            stage_en <= (state_nx == RUN) ? ({{(NUM_STAGES-1){1'b0}}, 1'b1} << idx_nx) : '0;
            if (state == IDLE && start) begin
                ans_valid <= 1'b0;
            end
            if (state == RUN && state_nx == FIN) begin
                ans       <= fc_ans;
                ans_valid <= 1'b1;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    assign busy      = (state == RUN) || (state == GAP);
    assign done      = (state == FIN);
    assign cur_stage = idx;

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (state == RUN),
        .expired(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == RUN && !finish_hit && timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Self-checking bench for lenet_layer_sequencer with a frame-level reference model.
module tb_lenet_layer_sequencer;

    localparam int N  = 6;
    localparam int AW = 4;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  stage_finish;
    logic [AW-1:0] fc_ans;

    logic [N-1:0]  stage_en,  stage_en_w;
    logic          busy,      busy_w;
    logic [2:0]    cur_stage, cur_stage_w;
    logic          done,      done_w;
    logic [AW-1:0] ans,       ans_w;
    logic          ans_valid, ans_valid_w;
    logic [FW-1:0] frame_cnt;
    logic [1:0]    frame_cnt_w;
    logic          err,       err_w;

    lenet_layer_sequencer #(.NUM_STAGES(N), .ANS_W(AW), .FRAME_CNT_W(FW), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .start(start), .stage_en(stage_en), .stage_finish(stage_finish),
        .fc_ans(fc_ans), .busy(busy), .cur_stage(cur_stage), .done(done), .ans(ans),
        .ans_valid(ans_valid), .frame_cnt(frame_cnt), .err(err)
    );

    lenet_layer_sequencer #(.NUM_STAGES(N), .ANS_W(AW), .FRAME_CNT_W(2), .TIMEOUT_CYC(50)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .stage_en(stage_en_w), .stage_finish(stage_finish),
        .fc_ans(fc_ans), .busy(busy_w), .cur_stage(cur_stage_w), .done(done_w), .ans(ans_w),
        .ans_valid(ans_valid_w), .frame_cnt(frame_cnt_w), .err(err_w)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: frame-level bookkeeping only.
    int   exp_cnt;
    int   exp_cnt_w;
    int   exp_ans;
    bit   exp_err;

    function automatic logic [N-1:0] onehot(input int s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stage_finish = '0; fc_ans = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0; exp_cnt_w = 0; exp_ans = 0; exp_err = 1'b0;
        @(negedge clk);
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge after FIN (DUT idle).
    task automatic run_frame(input int lat[N], input logic [AW-1:0] ansv,
                             input int spur_s, input int busy_s, input int abort_s, input bit fin_start);
        logic [AW-1:0] e_ans;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < N; s++) begin
            checks++;
            if ({stage_en, cur_stage, busy, done, ans_valid, err} !== {onehot(s), 3'(s), 1'b1, 1'b0, 1'b0, exp_err}) begin
                failures++;
                $display("FAIL stage%0d_enter: en/cur/busy/done/valid/err got %b %0d %b%b%b%b want %b %0d 1001%b",
                         s, stage_en, cur_stage, busy, done, ans_valid, err, onehot(s), s, exp_err);
            end
            if (s == abort_s) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({stage_en, busy, done, ans_valid, frame_cnt, ans} !== '0) begin
                    failures++;
                    $display("FAIL async_reset: en=%b busy=%b done=%b valid=%b cnt=%0d ans=%0d want all 0",
                             stage_en, busy, done, ans_valid, frame_cnt, ans);
                end
                stage_finish = '0;
                exp_cnt = 0; exp_cnt_w = 0; exp_ans = 0; exp_err = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            for (int k = 0; k < lat[s]; k++) begin
                fc_ans = AW'($urandom);
                if (s == spur_s && k == 0) stage_finish[(s + 2) % N] = 1'b1;
                if (s == busy_s && k == 0) start = 1'b1;
                @(negedge clk);
                stage_finish = '0;
                start = 1'b0;
                checks++;
                if ({stage_en, cur_stage} !== {onehot(s), 3'(s)}) begin
                    failures++;
                    $display("FAIL stage%0d_hold: en=%b cur=%0d want en=%b cur=%0d", s, stage_en, cur_stage, onehot(s), s);
                end
            end
            stage_finish[s] = 1'b1;
            fc_ans = (s == N - 1) ? ansv : AW'($urandom);
            @(negedge clk);
            stage_finish = '0;
            fc_ans = AW'($urandom);
            if (s < N - 1) begin
                checks++;
                if ({stage_en, cur_stage, busy, done} !== {{N{1'b0}}, 3'(s + 1), 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL gap%0d: en=%b cur=%0d busy=%b done=%b want en=0 cur=%0d busy=1 done=0",
                             s, stage_en, cur_stage, busy, done, s + 1);
                end
                @(negedge clk);
            end
        end
        exp_cnt   = (exp_cnt + 1) % (1 << FW);
        exp_cnt_w = (exp_cnt_w + 1) % 4;
        exp_ans   = ansv;
        e_ans     = AW'(exp_ans);
        checks++;
        if ({stage_en, busy, done, ans_valid, err} !== {{N{1'b0}}, 1'b0, 1'b1, 1'b1, exp_err}) begin
            failures++;
            $display("FAIL fin_flags: en=%b busy=%b done=%b valid=%b err=%b want en=0 busy=0 done=1 valid=1 err=%b",
                     stage_en, busy, done, ans_valid, err, exp_err);
        end
        checks++;
        if (ans !== e_ans) begin
            failures++;
            $display("FAIL fin_ans: got %0d want %0d", ans, e_ans);
        end
        checks++;
        if (frame_cnt !== FW'(exp_cnt)) begin
            failures++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
        end
        checks++;
        if (frame_cnt_w !== 2'(exp_cnt_w)) begin
            failures++;
            $display("FAIL frame_cnt_wrap: got %0d want %0d", frame_cnt_w, exp_cnt_w);
        end
        start = fin_start;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({stage_en, busy, done, ans_valid, ans} !== {{N{1'b0}}, 1'b0, 1'b0, 1'b1, e_ans}) begin
            failures++;
            $display("FAIL post_fin_idle: en=%b busy=%b done=%b valid=%b ans=%0d want en=0 busy=0 done=0 valid=1 ans=%0d",
                     stage_en, busy, done, ans_valid, ans, e_ans);
        end
    endtask

    task automatic random_lat(output int lat[N]);
        for (int i = 0; i < N; i++) lat[i] = int'($urandom_range(0, 6));
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({stage_en, busy, cur_stage, done, ans, ans_valid, frame_cnt, err, frame_cnt_w} !== '0) begin
            failures++;
            $display("FAIL reset_state: en=%b busy=%b cur=%0d done=%b ans=%0d valid=%b cnt=%0d err=%b cntw=%0d want all 0",
                     stage_en, busy, cur_stage, done, ans, ans_valid, frame_cnt, err, frame_cnt_w);
        end
    endtask

    task automatic test_normal_frame();
        int lat[N];
        for (int i = 0; i < N; i++) lat[i] = 10;
        run_frame(lat, 4'd7, -1, -1, -1, 1'b0);
    endtask

    task automatic test_spurious_and_busy_start();
        int lat[N];
        random_lat(lat);
        lat[1] = lat[1] + 2;
        lat[2] = lat[2] + 2;
        run_frame(lat, AW'($urandom_range(0, 9)), 1, 2, -1, 1'b1);
    endtask

    task automatic test_mid_reset_back_to_back();
        int lat[N];
        logic [AW-1:0] answers[3] = '{4'd1, 4'd2, 4'd9};
        random_lat(lat);
        run_frame(lat, 4'd3, -1, -1, 4, 1'b0);
        for (int f = 0; f < 3; f++) begin
            random_lat(lat);
            run_frame(lat, answers[f], -1, -1, -1, 1'b0);
        end
        checks++;
        if (frame_cnt !== 16'd3 || ans !== 4'd9) begin
            failures++;
            $display("FAIL back_to_back: cnt=%0d ans=%0d want cnt=3 ans=9", frame_cnt, ans);
        end
    endtask

    task automatic test_wrap();
        int lat[N];
        do_reset();
        for (int f = 0; f < 4; f++) begin
            random_lat(lat);
            run_frame(lat, AW'($urandom_range(0, 9)), -1, -1, -1, 1'b0);
        end
        checks++;
        if (frame_cnt_w !== 2'd0 || frame_cnt !== 16'd4) begin
            failures++;
            $display("FAIL wrap: cntw=%0d cnt=%0d want cntw=0 cnt=4", frame_cnt_w, frame_cnt);
        end
    endtask

    task automatic test_random_frames();
        int lat[N];
        int spur;
        for (int f = 0; f < 6; f++) begin
            random_lat(lat);
            spur = int'($urandom_range(0, N - 1));
            lat[spur] = lat[spur] + 1;
            run_frame(lat, AW'($urandom), spur, -1, -1, bit'($urandom_range(0, 1)));
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int lat[N];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            stage_finish[s] = 1'b1;
            @(negedge clk);
            stage_finish = '0;
            @(negedge clk);
        end
        repeat (49) @(negedge clk);
        checks++;
        if ({err, stage_en} !== {1'b0, onehot(2)}) begin
            failures++;
            $display("FAIL timeout_run50: err=%b en=%b want err=0 en=%b", err, stage_en, onehot(2));
        end
        @(negedge clk);
        checks++;
        if ({err, stage_en, busy, done, ans_valid, frame_cnt} !== {1'b1, {N{1'b0}}, 3'b000, FW'(exp_cnt)}) begin
            failures++;
            $display("FAIL timeout_fire: err=%b en=%b busy=%b done=%b valid=%b cnt=%0d want err=1 en=0 000 cnt=%0d",
                     err, stage_en, busy, done, ans_valid, frame_cnt, exp_cnt);
        end
        exp_err = 1'b1;
        @(negedge clk);
        random_lat(lat);
        run_frame(lat, AW'($urandom_range(0, 9)), -1, -1, -1, 1'b0);
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: err=%b want 0", err);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_time_limit: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_normal_frame();
        test_spurious_and_busy_start();
        test_mid_reset_back_to_back();
        test_wrap();
        test_random_frames();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lenet_layer_sequencer.md
Name: lenet_layer_sequencer

Overview:
- Top-level frame controller for the LeNet inference datapath.
- Runs the layer engines in order, one at a time: conv1, pool1, conv2, pool2, fc1, fc2.
- Each engine is driven by a level enable and reports a finish pulse; the sequencer hands the enable from layer to layer.
- On fc2 finish it latches the classifier answer, flags it valid, and counts completed frames.

Parameters:
- NUM_STAGES, 6, number of layer engines in sequence (min 2).
- ANS_W, 4, width of the classifier answer (digit 0-9).
- FRAME_CNT_W, 16, width of the completed-frame counter.
- TIMEOUT_CYC, 200000, per-stage watchdog limit in cycles (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to process one frame; ignored unless in IDLE.
- stage_en  out  NUM_STAGES  one-hot level enable; bit i drives layer i (bit 0 = conv_1_en).
- stage_finish  in  NUM_STAGES  finish pulses from the layer engines; bit NUM_STAGES-1 = fc_2_finish.
- fc_ans  in  ANS_W  answer from the last layer; valid in the cycle its finish is high.
- busy  out  1  high while a frame is in progress.
- cur_stage  out  $clog2(NUM_STAGES)  index of the active stage.
- done  out  1  one-cycle pulse when the frame completes.
- ans  out  ANS_W  latched answer.
- ans_valid  out  1  ans holds the result of the most recent frame.
- frame_cnt  out  FRAME_CNT_W  number of completed frames; wraps.
- err  out  1  sticky watchdog error; constant 0 without SEQ_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - stage_en=0, busy=0, cur_stage=0, done=0, ans=0, ans_valid=0, frame_cnt=0, err=0.
- Reset mid-frame:
  - All enables drop immediately (async).
  - In-flight finish pulses are lost.
  - The first start after release begins a new frame at stage 0.
- States: IDLE, RUN, GAP, FIN.
- IDLE:
  - start=1 -> RUN with idx=0.
  - ans_valid is cleared on the same edge.
- RUN:
  - stage_en = 1<<idx; busy=1.
  - stage_en[0] is high on the cycle after start is sampled (latency 1).
  - If stage_finish[idx]=1 and idx<NUM_STAGES-1: -> GAP, idx+1.
  - If stage_finish[idx]=1 and idx=NUM_STAGES-1: -> FIN; ans<=fc_ans.
  - stage_finish bits other than idx are ignored.
  - A finish in the same cycle the enable first rises is accepted.
- GAP:
  - Exactly one cycle with stage_en=0, so layers can clear their counters.
  - Then -> RUN.
  - cur_stage already shows the new idx during GAP.
- FIN:
  - done=1 and ans_valid=1 (held until the next start or reset).
  - frame_cnt+1, wrapping from all-ones to 0.
  - busy=0 in FIN.
  - -> IDLE.
- start while busy or in FIN: ignored, not queued.
- start in IDLE on the cycle after FIN: accepted normally.
- stage_en is registered, glitch-free, and never has more than one bit set.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on every entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC before finish: err<=1 (sticky until rst), stage_en=0, state -> IDLE.
  - No done pulse, ans unchanged, ans_valid stays 0, frame_cnt unchanged.
- When not defined:
  - No counter logic is built; err is tied 0.
  - The sequencer waits indefinitely in RUN.

Decomposition:
- Shared package lenet_seq_pkg holds:
  - State encoding localparams: IDLE=0, RUN=1, GAP=2, FIN=3.
  - Stage index constants: STG_CONV1=0 through STG_FC2=5.
  - Default ANS_W.
- One sub-module, seq_watchdog, holds the timeout counter; it is instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- Normal frame:
  - Stimulus: reset, start; each enabled stage returns finish 10 cycles after its enable rises; fc_ans=4'd7 with the last finish.
  - Required: stage_en steps 000001, 000010, ... 100000, with one zero cycle between stages; done pulses once; ans=7; ans_valid=1; frame_cnt=1.
- Spurious finish:
  - Stimulus: pulse stage_finish[3] while stage 1 is active.
  - Required: no advance; cur_stage stays 1.
- Start while busy:
  - Stimulus: start pulsed during stage 2.
  - Required: ignored; after completion frame_cnt=1, not 2.
- Mid-frame reset and back-to-back frames:
  - Stimulus: rst asserted during stage 4.
  - Required: stage_en=0 within the same cycle; ans_valid=0.
  - Stimulus: then three back-to-back frames with answers 1, 2, 9.
  - Required: frame_cnt=3, ans=9.
- Wrap:
  - Stimulus: FRAME_CNT_W=2, run 4 frames.
  - Required: frame_cnt goes 1, 2, 3, 0.
- Timeout (SEQ_TIMEOUT_EN, TIMEOUT_CYC=50):
  - Stimulus: stage 2 never finishes.
  - Required: err=1 at RUN cycle 50; stage_en=0; no done; err stays 1 through a following good frame until rst.
